// File: rtl/hwpe_eai_slave_pkg.sv
// hwpe_eai_slave_pkg: shared constants, FSM encoding and engine op names for the EAI responder
package hwpe_eai_slave_pkg;
   localparam logic [6:0] EAI_OPC_CUSTOM0 = 7'h0B;
   localparam int         EAI_NUM_OPS     = 10;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} eai_state_e;
   typedef enum logic [3:0] {
      OP_NOP, OP_LD_A, OP_LD_B, OP_MAC, OP_MUL, OP_ADD,
      OP_CLR, OP_RD_ACC, OP_CFG, OP_STAT
   } eai_op_e;
endpackage

// File: rtl/hwpe_eai_decode.sv
// hwpe_eai_decode: splits an EAI instruction into engine op, write-back flag and legality
module hwpe_eai_decode
   import hwpe_eai_slave_pkg::*;
#(
   parameter int OP_W    = 4,
   parameter int NUM_OPS = EAI_NUM_OPS
) (
   input  logic [31:0]     instr,
   output logic [OP_W-1:0] op,
   output logic            xd,
   output logic            legal
);
   logic [6:0] funct7;
   logic       unused_bits;
   always_comb begin
      funct7      = instr[31:25];
      op          = funct7[OP_W-1:0];
      xd          = instr[14];
      legal       = instr[6:0] == EAI_OPC_CUSTOM0 && (funct7 >> OP_W) == 7'd0 && int'(op) < NUM_OPS;
      unused_bits = ^{instr[24:15], instr[13:7]};
   end
endmodule

// File: rtl/hwpe_eai_slave.sv
// hwpe_eai_slave: EAI responder; one instruction in flight, issues an engine command and
// answers with exactly one tagged response (result, engine error, illegal or timeout)
module hwpe_eai_slave
   import hwpe_eai_slave_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ITAG_W  = 2,
   parameter int OP_W    = 4,
   parameter int NUM_OPS = EAI_NUM_OPS,
   parameter int TMO_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              eai_req_valid,
   output logic              eai_req_ready,
   input  logic [31:0]       eai_req_instr,
   input  logic [DATA_W-1:0] eai_req_rs1,
   input  logic [DATA_W-1:0] eai_req_rs2,
   input  logic [ITAG_W-1:0] eai_req_itag,
   output logic              eai_rsp_valid,
   input  logic              eai_rsp_ready,
   output logic [DATA_W-1:0] eai_rsp_wdat,
   output logic [ITAG_W-1:0] eai_rsp_itag,
   output logic              eai_rsp_err,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [OP_W-1:0]   cmd_op,
   output logic [DATA_W-1:0] cmd_rs1,
   output logic [DATA_W-1:0] cmd_rs2,
   output logic              cmd_xd,
   input  logic              done_valid,
   input  logic [DATA_W-1:0] done_data,
   input  logic              done_err
);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

   eai_state_e        state, state_nxt;
   logic [TMO_W-1:0]  cnt;
   logic [OP_W-1:0]   dec_op;
   logic              dec_xd, dec_legal;
   logic              req_hs, cmd_hs, done_take, tmo;

   hwpe_eai_decode #(.OP_W(OP_W), .NUM_OPS(NUM_OPS)) u_dec (
      .instr (eai_req_instr),
      .op    (dec_op),
      .xd    (dec_xd),
      .legal (dec_legal)
   );

   always_comb begin
      req_hs    = eai_req_valid & eai_req_ready;
      cmd_hs    = cmd_valid & cmd_ready;
      // completion counts while waiting, or when it lands on the command handshake itself
      done_take = done_valid & (state == ST_WAIT | cmd_hs);
      tmo       = state == ST_WAIT && cnt == TMO_LAST;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (eai_req_valid) state_nxt = dec_legal ? ST_ISSUE : ST_RESP;
         ST_ISSUE: if (cmd_ready) state_nxt = done_valid ? ST_RESP : ST_WAIT;
         ST_WAIT:  if (done_valid || tmo) state_nxt = ST_RESP;
         ST_RESP:  if (eai_rsp_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      eai_req_ready = state == ST_IDLE;
      cmd_valid     = state == ST_ISSUE;
      eai_rsp_valid = state == ST_RESP;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cmd_op       <= '0;
         cmd_rs1      <= '0;
         cmd_rs2      <= '0;
         cmd_xd       <= 1'b0;
         eai_rsp_itag <= '0;
         eai_rsp_wdat <= '0;
         eai_rsp_err  <= 1'b0;
         cnt          <= '0;
      end else begin
         if (req_hs) begin
            cmd_op       <= dec_op;
            cmd_rs1      <= eai_req_rs1;
            cmd_rs2      <= eai_req_rs2;
            cmd_xd       <= dec_xd;
            eai_rsp_itag <= eai_req_itag;
            eai_rsp_wdat <= '0;
            eai_rsp_err  <= ~dec_legal;
         end
         if (cmd_hs)                cnt <= '0;
         else if (state == ST_WAIT) cnt <= cnt + 1'b1;
         if (done_take) begin
            eai_rsp_wdat <= cmd_xd ? done_data : '0;
            eai_rsp_err  <= done_err;
         end else if (tmo) begin
            eai_rsp_wdat <= '0;
            eai_rsp_err  <= 1'b1;
         end
      end
endmodule

// File: tb/tb_hwpe_eai_slave.sv
// tb_hwpe_eai_slave: directed stimulus with a response scoreboard checked by an independent monitor
module tb_hwpe_eai_slave;
   typedef struct {
      logic [31:0] wdat;
      logic [1:0]  itag;
      logic        err;
   } rsp_t;

   logic        clk = 0, rst_n = 0;
   logic        eai_req_valid = 0, eai_req_ready;
   logic [31:0] eai_req_instr = 0, eai_req_rs1 = 0, eai_req_rs2 = 0;
   logic [1:0]  eai_req_itag = 0;
   logic        eai_rsp_valid, eai_rsp_ready = 1;
   logic [31:0] eai_rsp_wdat;
   logic [1:0]  eai_rsp_itag;
   logic        eai_rsp_err;
   logic        cmd_valid, cmd_ready = 1;
   logic [3:0]  cmd_op;
   logic [31:0] cmd_rs1, cmd_rs2;
   logic        cmd_xd;
   logic        done_valid = 0;
   logic [31:0] done_data = 0;
   logic        done_err = 0;

   int   checks = 0, errors = 0;
   rsp_t sb[$];

   hwpe_eai_slave #(.DATA_W(32), .ITAG_W(2), .OP_W(4), .NUM_OPS(10), .TMO_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .eai_req_valid(eai_req_valid), .eai_req_ready(eai_req_ready), .eai_req_instr(eai_req_instr),
      .eai_req_rs1(eai_req_rs1), .eai_req_rs2(eai_req_rs2), .eai_req_itag(eai_req_itag),
      .eai_rsp_valid(eai_rsp_valid), .eai_rsp_ready(eai_rsp_ready), .eai_rsp_wdat(eai_rsp_wdat),
      .eai_rsp_itag(eai_rsp_itag), .eai_rsp_err(eai_rsp_err),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rs1(cmd_rs1),
      .cmd_rs2(cmd_rs2), .cmd_xd(cmd_xd),
      .done_valid(done_valid), .done_data(done_data), .done_err(done_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] wdat, input logic [1:0] itag, input logic err);
      rsp_t e;
      e.wdat = wdat;
      e.itag = itag;
      e.err  = err;
      sb.push_back(e);
   endtask

   // returns at posedge+1 of the accepting edge
   task automatic send_req(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] tag);
      int n = 0;
      eai_req_valid = 1;
      eai_req_instr = instr;
      eai_req_rs1   = a;
      eai_req_rs2   = b;
      eai_req_itag  = tag;
      @(negedge clk);
      while (!eai_req_ready && n < 60) begin
         n++;
         @(negedge clk);
      end
      if (!eai_req_ready) chk("req_accept_timeout", 32'(eai_req_ready), 32'd1);
      @(posedge clk);
      #1 eai_req_valid = 0;
   endtask

   task automatic engine_done(input logic [31:0] data, input logic err, input int delay);
      repeat (delay) @(posedge clk);
      #1 done_valid = 1;
      done_data = data;
      done_err  = err;
      @(posedge clk);
      #1 done_valid = 0;
      chk("rsp_valid_after_done", 32'(eai_rsp_valid), 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!eai_req_ready && n < 60) begin
         n++;
         @(negedge clk);
      end
      if (!eai_req_ready) chk("idle_timeout", 32'(eai_req_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_req_ready", 32'(eai_req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(eai_rsp_valid), 32'd0);
      chk("rst_rsp_wdat", eai_rsp_wdat, 32'd0);
      chk("rst_rsp_itag", 32'(eai_rsp_itag), 32'd0);
      chk("rst_rsp_err", 32'(eai_rsp_err), 32'd0);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_cmd_op", 32'(cmd_op), 32'd0);
      chk("rst_cmd_rs1", cmd_rs1, 32'd0);
      chk("rst_cmd_rs2", cmd_rs2, 32'd0);
      chk("rst_cmd_xd", 32'(cmd_xd), 32'd0);
   endtask

   initial forever begin
      rsp_t e;
      @(negedge clk);
      if (rst_n && eai_rsp_valid && eai_rsp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got itag %0d wdat %h with nothing expected", eai_rsp_itag, eai_rsp_wdat);
         end else begin
            e = sb.pop_front();
            chk("rsp_wdat", eai_rsp_wdat, e.wdat);
            chk("rsp_itag", 32'(eai_rsp_itag), 32'(e.itag));
            chk("rsp_err", 32'(eai_rsp_err), 32'(e.err));
         end
      end
   end

   initial begin
      int w, n;
      #2 chk_reset_outputs();
      #20 rst_n = 1;
      @(posedge clk);
      #1;
      // legal op 2 with write-back
      push(32'h1234, 2'd1, 1'b0);
      send_req(32'h0400_400B, 32'hA5A5_0001, 32'h5A5A_0002, 2'd1);
      chk("t1_cmd_valid", 32'(cmd_valid), 32'd1);
      chk("t1_cmd_op", 32'(cmd_op), 32'd2);
      chk("t1_cmd_xd", 32'(cmd_xd), 32'd1);
      chk("t1_cmd_rs1", cmd_rs1, 32'hA5A5_0001);
      chk("t1_cmd_rs2", cmd_rs2, 32'h5A5A_0002);
      engine_done(32'h1234, 1'b0, 5);
      wait_idle();
      // no write-back: result suppressed
      push(32'h0, 2'd2, 1'b0);
      send_req(32'h0200_000B, 32'h11, 32'h22, 2'd2);
      chk("t2_cmd_op", 32'(cmd_op), 32'd1);
      chk("t2_cmd_xd", 32'(cmd_xd), 32'd0);
      engine_done(32'hFFFF, 1'b0, 2);
      wait_idle();
      // illegal opcode, then illegal funct7
      push(32'h0, 2'd3, 1'b1);
      send_req(32'h0400_4033, 32'h1, 32'h2, 2'd3);
      chk("t3_no_cmd", 32'(cmd_valid), 32'd0);
      chk("t3_rsp_valid", 32'(eai_rsp_valid), 32'd1);
      wait_idle();
      push(32'h0, 2'd0, 1'b1);
      send_req(32'h1E00_400B, 32'h1, 32'h2, 2'd0);
      chk("t4_no_cmd", 32'(cmd_valid), 32'd0);
      chk("t4_rsp_valid", 32'(eai_rsp_valid), 32'd1);
      wait_idle();
      // backpressure on both channels, second request held by the core
      cmd_ready = 0;
      eai_rsp_ready = 0;
      push(32'h5555, 2'd2, 1'b0);
      send_req(32'h0600_400B, 32'hCAFE_0001, 32'hBEEF_0002, 2'd2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_cmd_valid", 32'(cmd_valid), 32'd1);
         chk("bp_cmd_op", 32'(cmd_op), 32'd3);
         chk("bp_cmd_rs1", cmd_rs1, 32'hCAFE_0001);
         chk("bp_cmd_rs2", cmd_rs2, 32'hBEEF_0002);
         chk("bp_req_ready", 32'(eai_req_ready), 32'd0);
      end
      @(posedge clk);
      #1 cmd_ready = 1;
      engine_done(32'h5555, 1'b0, 1);
      eai_req_valid = 1;
      eai_req_instr = 32'h0800_400B;
      eai_req_rs1   = 32'h3;
      eai_req_rs2   = 32'h4;
      eai_req_itag  = 2'd3;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", 32'(eai_rsp_valid), 32'd1);
         chk("bp_rsp_wdat", eai_rsp_wdat, 32'h5555);
         chk("bp_rsp_itag", 32'(eai_rsp_itag), 32'd2);
         chk("bp_req_ready", 32'(eai_req_ready), 32'd0);
      end
      @(posedge clk);
      #1 eai_rsp_ready = 1;
      @(posedge clk);
      #1 chk("bp_bubble_req_ready", 32'(eai_req_ready), 32'd1);
      // second request completes on the same edge as its command handshake
      push(32'h77, 2'd3, 1'b0);
      send_req(32'h0800_400B, 32'h3, 32'h4, 2'd3);
      chk("t5_cmd_op", 32'(cmd_op), 32'd4);
      engine_done(32'h77, 1'b0, 0);
      wait_idle();
      // timeout with a late completion that must be ignored
      push(32'h0, 2'd1, 1'b1);
      send_req(32'h0400_400B, 32'h9, 32'h8, 2'd1);
      w = 0;
      n = 0;
      while (!eai_rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
         if (!eai_rsp_valid && !cmd_valid && !eai_req_ready) w++;
      end
      chk("tmo_wait_cycles", 32'(w), 32'd15);
      @(posedge clk);
      #1 done_valid = 1;
      done_data = 32'hDEAD;
      @(posedge clk);
      #1 done_valid = 0;
      chk("late_done_no_rsp", 32'(eai_rsp_valid), 32'd0);
      chk("late_done_idle", 32'(eai_req_ready), 32'd1);
      push(32'hABCD, 2'd0, 1'b0);
      send_req(32'h0000_400B, 32'h5, 32'h6, 2'd0);
      engine_done(32'hABCD, 1'b0, 3);
      wait_idle();
      // reset in WAIT drops the transaction
      send_req(32'h0400_400B, 32'h77, 32'h88, 2'd2);
      repeat (3) @(posedge clk);
      #3 rst_n = 0;
      #1 chk_reset_outputs();
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      push(32'h4242, 2'd3, 1'b0);
      send_req(32'h0400_400B, 32'h1, 32'h2, 2'd3);
      engine_done(32'h4242, 1'b0, 2);
      wait_idle();
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
